// File: rtl/raymarch_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : raymarch_dispatcher
// Purpose  : raster-order pixel issue to NUM_CORES raymarchers, round-robin
//            collection of results onto one valid/ready framebuffer port.
//            Optional DISPATCH_STATS_EN adds busy/stall cycle counters.
// Revision : 1.0  initial release
// ============================================================================
module raymarch_dispatcher #(
  parameter int WIDTH     = 320,
  parameter int HEIGHT    = 180,
  parameter int NUM_CORES = 4,
  parameter int COORD_W   = 16,
  parameter int COLOR_W   = 8,
  parameter int ADDR_W    = $clog2(WIDTH*HEIGHT)
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           start_in,
  output logic                           busy_out,
  output logic                           frame_done_out,
  output logic [NUM_CORES-1:0]           core_start_out,
  output logic [NUM_CORES*COORD_W-1:0]   core_x_out,
  output logic [NUM_CORES*COORD_W-1:0]   core_y_out,
  input  logic [NUM_CORES-1:0]           core_done_in,
  input  logic [NUM_CORES*3*COLOR_W-1:0] core_rgb_in,
  output logic                           fb_valid_out,
  input  logic                           fb_ready_in,
  output logic [ADDR_W-1:0]              fb_addr_out,
  output logic [3*COLOR_W-1:0]           fb_rgb_out
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]                    stat_cycles_out,
  output logic [31:0]                    stat_stall_out
`endif
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int RGB_W = 3*COLOR_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] CS_IDLE = 2'd0;
  localparam logic [1:0] CS_BUSY = 2'd1;
  localparam logic [1:0] CS_HOLD = 2'd2;

  logic [1:0]         state;
  logic [1:0]         cst     [NUM_CORES];
  logic [1:0]         cst_nxt [NUM_CORES];
  logic [COORD_W-1:0] cx      [NUM_CORES];
  logic [COORD_W-1:0] cy      [NUM_CORES];
  logic [RGB_W-1:0]   crgb    [NUM_CORES];
  logic [COORD_W-1:0] scan_x, scan_y;
  logic [IDX_W-1:0]   rr_ptr, grant;
  logic               issue_en, issue_vld, idle_found, scan_last;
  logic [IDX_W-1:0]   issue_idx;
  logic [NUM_CORES-1:0] cand;
  logic               sel_vld;
  logic [IDX_W-1:0]   sel_idx, cand_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic               load_en, fb_fire, fb_valid_nxt, all_idle_nxt;

  assign busy_out       = (state != ST_IDLE);
  assign frame_done_out = (state == ST_DONE);
  assign issue_en  = (state == ST_RUN) || ((state == ST_IDLE) && start_in);
  assign scan_last = (scan_x == COORD_W'(WIDTH-1)) && (scan_y == COORD_W'(HEIGHT-1));
  assign fb_fire   = fb_valid_out && fb_ready_in;
  assign load_en   = !fb_valid_out || fb_ready_in;

  genvar g;
  generate
    for (g = 0; g < NUM_CORES; g++) begin : g_core
      assign core_x_out[g*COORD_W +: COORD_W] = cx[g];
      assign core_y_out[g*COORD_W +: COORD_W] = cy[g];
      // A result already sitting in the output stage is not re-arbitrated.
      assign cand[g] = (cst[g] == CS_HOLD) && !(fb_valid_out && (grant == IDX_W'(g)));
    end
  endgenerate

  always_comb begin
    idle_found = 1'b0;
    issue_idx  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!idle_found && (cst[i] == CS_IDLE)) begin
        idle_found = 1'b1;
        issue_idx  = IDX_W'(i);
      end
    end
    issue_vld = issue_en && idle_found;
  end

  always_comb begin
    sel_vld  = 1'b0;
    sel_idx  = '0;
    cand_idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand_idx = IDX_W'((int'(rr_ptr) + k) % NUM_CORES);
      if (!sel_vld && cand[cand_idx]) begin
        sel_vld = 1'b1;
        sel_idx = cand_idx;
      end
    end
  end

  assign sel_addr     = ADDR_W'(32'(cy[sel_idx]) * 32'(WIDTH) + 32'(cx[sel_idx]));
  assign fb_valid_nxt = load_en ? sel_vld : fb_valid_out;

  always_comb begin
    all_idle_nxt = 1'b1;
    for (int i = 0; i < NUM_CORES; i++) begin
      cst_nxt[i] = cst[i];
      case (cst[i])
        CS_IDLE: if (issue_vld && (issue_idx == IDX_W'(i))) cst_nxt[i] = CS_BUSY;
        CS_BUSY: if (core_done_in[i]) cst_nxt[i] = CS_HOLD;
        CS_HOLD: if (fb_fire && (grant == IDX_W'(i))) cst_nxt[i] = CS_IDLE;
        default: cst_nxt[i] = CS_IDLE;
      endcase
      if (cst_nxt[i] != CS_IDLE) all_idle_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state  <= ST_IDLE;
      scan_x <= '0;
      scan_y <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (start_in) state <= scan_last ? ST_DRAIN : ST_RUN;
        ST_RUN:   if (issue_vld && scan_last) state <= ST_DRAIN;
        ST_DRAIN: if (all_idle_nxt && !fb_valid_nxt) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
      if (issue_vld) begin
        if (scan_x == COORD_W'(WIDTH-1)) begin
          scan_x <= '0;
          scan_y <= (scan_y == COORD_W'(HEIGHT-1)) ? '0 : scan_y + 1'b1;
        end else begin
          scan_x <= scan_x + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      core_start_out <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        cst[i]  <= CS_IDLE;
        cx[i]   <= '0;
        cy[i]   <= '0;
        crgb[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        cst[i] <= cst_nxt[i];
        core_start_out[i] <= issue_vld && (issue_idx == IDX_W'(i));
        if (issue_vld && (issue_idx == IDX_W'(i))) begin
          cx[i] <= scan_x;
          cy[i] <= scan_y;
        end
        if ((cst[i] == CS_BUSY) && core_done_in[i])
          crgb[i] <= core_rgb_in[i*RGB_W +: RGB_W];
      end
    end
  end

  // Output stage refills on the handshake cycle to sustain one write per cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fb_valid_out <= 1'b0;
      fb_addr_out  <= '0;
      fb_rgb_out   <= '0;
      grant        <= '0;
      rr_ptr       <= '0;
    end else if (load_en) begin
      fb_valid_out <= sel_vld;
      if (sel_vld) begin
        fb_addr_out <= sel_addr;
        fb_rgb_out  <= crgb[sel_idx];
        grant       <= sel_idx;
        rr_ptr      <= (sel_idx == IDX_W'(NUM_CORES-1)) ? '0 : sel_idx + 1'b1;
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stat_cycles_out <= '0;
      stat_stall_out  <= '0;
    end else if ((state == ST_IDLE) && start_in) begin
      stat_cycles_out <= '0;
      stat_stall_out  <= '0;
    end else begin
      if (busy_out && (stat_cycles_out != 32'hFFFF_FFFF))
        stat_cycles_out <= stat_cycles_out + 1'b1;
      if (fb_valid_out && !fb_ready_in && (stat_stall_out != 32'hFFFF_FFFF))
        stat_stall_out <= stat_stall_out + 1'b1;
    end
  end
`else
  // Default build carries no statistics counters.
`endif

endmodule
`default_nettype wire

// File: tb/tb_raymarch_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_raymarch_dispatcher
// Purpose  : directed bench for raymarch_dispatcher, 4x2 frame, two cores.
// Revision : 1.0  initial release
// ============================================================================
module tb_raymarch_dispatcher;
  localparam int W = 4, H = 2, N = 2, CW = 16, RGBW = 24;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b1;
  logic busy_out, frame_done_out, fb_valid_out;
  logic [N-1:0] core_start_out;
  logic [N*CW-1:0] core_x_out, core_y_out;
  logic [N-1:0] done_v = '0;
  logic [N*RGBW-1:0] rgb_v = '0;
  logic [2:0] fb_addr_out;
  logic [RGBW-1:0] fb_rgb_out;
`ifdef DISPATCH_STATS_EN
  logic [31:0] stat_cycles_out, stat_stall_out;
`endif

  raymarch_dispatcher #(.WIDTH(W), .HEIGHT(H), .NUM_CORES(N), .COORD_W(CW), .COLOR_W(8)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .busy_out(busy_out),
    .frame_done_out(frame_done_out), .core_start_out(core_start_out),
    .core_x_out(core_x_out), .core_y_out(core_y_out), .core_done_in(done_v),
    .core_rgb_in(rgb_v), .fb_valid_out(fb_valid_out), .fb_ready_in(ready),
    .fb_addr_out(fb_addr_out), .fb_rgb_out(fb_rgb_out)
`ifdef DISPATCH_STATS_EN
    , .stat_cycles_out(stat_cycles_out), .stat_stall_out(stat_stall_out)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input int x, input int y);
    logic [7:0] r, g, b;
    r = 8'(16*x + y + 1);
    g = 8'(64 + 3*y + x);
    b = 8'(x ^ (y*16) ^ 90);
    return {r, g, b};
  endfunction

  // Core models: fixed latency per core, colour derived from the coordinate.
  int lat [N];
  bit mbusy [N];
  int mcnt [N], mcx [N], mcy [N];
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      done_v[i] = 1'b0;
      if (rst) begin
        mbusy[i] = 1'b0;
      end else if (core_start_out[i]) begin
        mbusy[i] = 1'b1;
        mcnt[i]  = lat[i];
        mcx[i]   = int'(core_x_out[i*CW +: CW]);
        mcy[i]   = int'(core_y_out[i*CW +: CW]);
      end else if (mbusy[i]) begin
        mcnt[i]--;
        if (mcnt[i] == 0) begin
          done_v[i] = 1'b1;
          rgb_v[i*RGBW +: RGBW] = exp_rgb(mcx[i], mcy[i]);
          mbusy[i] = 1'b0;
        end
      end
    end
  end

  int frame_id = 0, seen_id = 0, cyc = 0;
  int wr_cnt, done_cnt, issue_cnt, rgb_bad, stab_viol, hold_viol, timing_viol;
  int last_hs_cyc, first_core, busy_cyc;
  int addr_cnt [8];
  bit pend [N], clr [N];
  bit prev_v = 0, prev_r = 0, prev_done = 0, matched;
  logic [2:0] prev_a;
  logic [RGBW-1:0] prev_rgb;

  // Release of a HOLD core is deferred one sample so a same-cycle reissue is caught.
  always @(negedge clk) begin
    cyc++;
    if (frame_id != seen_id) begin
      seen_id = frame_id;
      wr_cnt = 0; done_cnt = 0; issue_cnt = 0; rgb_bad = 0; stab_viol = 0;
      hold_viol = 0; timing_viol = 0; last_hs_cyc = -10; first_core = -1; busy_cyc = 0;
      for (int a = 0; a < 8; a++) addr_cnt[a] = 0;
    end
    if (rst) begin
      for (int i = 0; i < N; i++) begin pend[i] = 0; clr[i] = 0; end
      prev_v = 0; prev_done = 0;
    end else begin
      if (busy_out) busy_cyc++;
      for (int i = 0; i < N; i++)
        if (core_start_out[i]) begin
          issue_cnt++;
          if (pend[i]) hold_viol++;
        end
      for (int i = 0; i < N; i++) if (clr[i]) begin pend[i] = 0; clr[i] = 0; end
      for (int i = 0; i < N; i++) if (done_v[i]) pend[i] = 1;
      if (prev_v && !prev_r &&
          (!fb_valid_out || fb_addr_out !== prev_a || fb_rgb_out !== prev_rgb))
        stab_viol++;
      if (fb_valid_out && ready) begin
        wr_cnt++;
        addr_cnt[fb_addr_out]++;
        if (fb_rgb_out !== exp_rgb(int'(fb_addr_out) % W, int'(fb_addr_out) / W)) rgb_bad++;
        last_hs_cyc = cyc;
        matched = 0;
        for (int i = 0; i < N; i++)
          if (!matched && pend[i] && !clr[i] && (mcy[i]*W + mcx[i]) == int'(fb_addr_out)) begin
            matched = 1;
            clr[i] = 1;
            if (first_core < 0) first_core = i;
          end
        if (!matched) rgb_bad++;
      end
      if (prev_done && (busy_out || frame_done_out)) timing_viol++;
      if (frame_done_out) begin
        done_cnt++;
        if (!busy_out || cyc != last_hs_cyc + 1) timing_viol++;
      end
      prev_done = frame_done_out;
      prev_v = fb_valid_out; prev_r = ready; prev_a = fb_addr_out; prev_rgb = fb_rgb_out;
    end
  end

  task automatic start_frame(input string tag);
    frame_id++;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_busy_rise"}, busy_out, 1);
    chk({tag, "_first_issue"}, core_start_out, 2'b01);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin @(posedge clk); #1; n++; end
    chk({tag, "_done_seen"}, done_cnt != 0, 1);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_frame(input string tag);
    int odd = 0;
    for (int a = 0; a < 8; a++) if (addr_cnt[a] != 1) odd++;
    chk({tag, "_writes"}, wr_cnt, 8);
    chk({tag, "_addr_once"}, odd, 0);
    chk({tag, "_rgb"}, rgb_bad, 0);
    chk({tag, "_stable"}, stab_viol, 0);
    chk({tag, "_hold_issue"}, hold_viol, 0);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_done_timing"}, timing_viol, 0);
    chk({tag, "_busy_low"}, busy_out, 0);
  endtask

  task automatic wait_until_writes(input int k);
    int n = 0;
    while (wr_cnt < k && n < 500) begin @(posedge clk); #1; n++; end
    chk("wait_writes", wr_cnt >= k, 1);
  endtask

  initial begin
    lat[0] = 3; lat[1] = 3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_out, 0);
    chk("rst_valid", fb_valid_out, 0);
    chk("rst_start", core_start_out, 0);
    chk("rst_done", frame_done_out, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    start_frame("t1"); wait_done("t1"); check_frame("t1");

    lat[0] = 10; lat[1] = 1;
    start_frame("t2"); wait_done("t2"); check_frame("t2");
    chk("t2_first_core", 64'(first_core), 1);

    lat[0] = 3; lat[1] = 3;
    start_frame("t3");
    wait_until_writes(2);
    ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    ready = 1'b1;
    wait_done("t3"); check_frame("t3");

    start_frame("t4");
    begin
      int n = 0;
      while (issue_cnt < 3 && n < 200) begin @(posedge clk); #1; n++; end
      chk("t4_three_issues", issue_cnt >= 3, 1);
    end
    rst = 1'b1;
    #1;
    chk("t4_rst_busy", busy_out, 0);
    chk("t4_rst_start", core_start_out, 0);
    chk("t4_rst_x", core_x_out, 0);
    chk("t4_rst_y", core_y_out, 0);
    chk("t4_rst_valid", fb_valid_out, 0);
    chk("t4_rst_addr", fb_addr_out, 0);
    chk("t4_rst_rgb", fb_rgb_out, 0);
    chk("t4_rst_done", frame_done_out, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t4b_x0", core_x_out[CW-1:0], 0);
    start_frame("t4b"); wait_done("t4b"); check_frame("t4b");

    start_frame("t5");
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t5"); check_frame("t5");

`ifdef DISPATCH_STATS_EN
    start_frame("t6");
    begin
      int n = 0;
      while (!fb_valid_out && n < 200) begin @(posedge clk); #1; n++; end
      chk("t6_valid_seen", fb_valid_out, 1);
    end
    ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    ready = 1'b1;
    wait_done("t6"); check_frame("t6");
    chk("t6_stall", stat_stall_out, 5);
    chk("t6_cycles", stat_cycles_out, 64'(busy_cyc));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/raymarch_dispatcher.md
# raymarch_dispatcher

Frame-level work distributor between the pixel scan source and a bank of `NUM_CORES` parallel `raymarcher` cores. It walks the frame in raster order and issues one pixel coordinate per idle core. It collects each core's `pixel_done` colour result and serialises the results onto a single valid/ready framebuffer write port with a linear address. Results leave in completion order, not raster order.

## Interface
Parameters:
- `WIDTH`, 320: frame width in pixels.
- `HEIGHT`, 180: frame height in pixels.
- `NUM_CORES`, 4: number of attached raymarcher cores (1..16).
- `COORD_W`, 16: coordinate width.
- `COLOR_W`, 8: bits per colour channel.
- `ADDR_W`, `$clog2(WIDTH*HEIGHT)`: framebuffer address width.

Ports:
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  asynchronous, active-high reset.
- `start_in`  in  1  begin a frame; sampled only in IDLE.
- `busy_out`  out  1  high from the cycle after start is accepted until the frame is done.
- `frame_done_out`  out  1  one-cycle pulse after the last framebuffer write.
- `core_start_out`  out  NUM_CORES  one-cycle issue pulse per core.
- `core_x_out`  out  NUM_CORES*COORD_W  per-core x; held stable while that core is busy.
- `core_y_out`  out  NUM_CORES*COORD_W  per-core y; held stable while that core is busy.
- `core_done_in`  in  NUM_CORES  per-core `pixel_done` pulse.
- `core_rgb_in`  in  NUM_CORES*3*COLOR_W  per-core {r,g,b}; valid in the `core_done_in` cycle.
- `fb_valid_out`  out  1  write request.
- `fb_ready_in`  in  1  framebuffer accepts the write.
- `fb_addr_out`  out  ADDR_W  linear address, y*WIDTH+x.
- `fb_rgb_out`  out  3*COLOR_W  {r,g,b}.

## Operation
- FSM states:
  - IDLE: `start_in` moves to RUN.
  - RUN: the last pixel has been issued moves to DRAIN.
  - DRAIN: all cores idle and no pending results moves to DONE.
  - DONE: pulses `frame_done_out` for one cycle, then returns to IDLE.
- Per-core state: IDLE, BUSY (issued, awaiting done), HOLD (result latched, awaiting fb accept).
- Issue (RUN only): at most one pixel per cycle, to the lowest-index IDLE core.
  - Latch the current (x,y) into that core's coordinate registers and pulse its `core_start_out`.
  - Advance the scan counter: x wraps at WIDTH-1 and increments y; issue of (WIDTH-1, HEIGHT-1) ends RUN.
- Capture: `core_done_in[i]` while core i is BUSY latches rgb and moves core i to HOLD. `core_done_in` for a non-BUSY core is ignored.
- Output: a round-robin arbiter among HOLD cores, with the pointer starting after the last granted core, selects one result into a registered output stage.
  - `fb_valid_out`, `fb_addr_out` and `fb_rgb_out` are held stable until `fb_valid_out && fb_ready_in`.
  - On that handshake the granted core returns to IDLE. It is eligible for issue the following cycle, never the same cycle.
- Address arithmetic: computed from the coordinates latched at issue, as y*WIDTH+x, unsigned, truncated to ADDR_W.
- `start_in` outside IDLE is ignored.
- Reset (asynchronous, any state): FSM to IDLE, all cores to IDLE, scan counter to (0,0), arbiter pointer to 0. The attached cores must share `rst_in`.
- Reset value of every output is 0.

## Timing
- `start_in` sampled high in IDLE at edge t: `busy_out` and the first `core_start_out` go high at t+1.
- Issue throughput is one pixel per cycle while an IDLE core exists.
- `core_done_in` at edge t: core in HOLD at t+1; `fb_valid_out` earliest at t+2.
- Sustained output rate is one write per cycle with `fb_ready_in` high.
- Final handshake at edge t: `frame_done_out` is high for cycle t+1 and `busy_out` is low from t+2.
- Done and handshake for different cores in the same cycle are both honoured.

## Configuration
- `DISPATCH_STATS_EN` defined:
  - Adds `stat_cycles_out` (out, 32): cycles with `busy_out` high in the last frame.
  - Adds `stat_stall_out` (out, 32): cycles with `fb_valid_out && !fb_ready_in`.
  - Both counters clear on start acceptance and saturate at all-ones.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- WIDTH=4, HEIGHT=2, NUM_CORES=2, core models with 3-cycle latency, `fb_ready_in`=1 -> 8 writes, addresses 0..7 each exactly once, rgb matching the model, one `frame_done_out` pulse.
- Same config, core 0 latency 10 and core 1 latency 1 -> every address 0..7 written once; core 1 results precede core 0's; no core is issued while in HOLD.
- `fb_ready_in` low for 20 cycles mid-frame -> addr/rgb stable throughout, no `core_start_out` to HOLD cores, frame completes after release with 8 writes.
- Assert `rst_in` after 3 issues -> all outputs 0 immediately. A subsequent start re-issues from (0,0) and completes normally.
- Pulse `start_in` during RUN -> ignored; still exactly 8 writes and one `frame_done_out`.
- With `DISPATCH_STATS_EN`, hold `fb_ready_in` low for 5 cycles while valid -> `stat_stall_out`=5 at frame end.
